// File: rtl/multi_button_debouncer.sv
// multi_button_debouncer: N independent push-button channels, each with a 2-flop
// synchroniser, counter debounce filter, press/release event pulses and optional hold-to-repeat.
// Latency: press seen before edge k -> level/press_pulse after edge k+1+DEBOUNCE_CYCLES. No backpressure: pulses are fire-and-forget.
// Ports: clk/rst (sync, active-high); btn_in raw pins; level debounced state (1 = pressed);
//        press_pulse/release_pulse/repeat_pulse one-cycle events per channel.
module multi_button_debouncer #(
  parameter int NUM_BTNS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 2400000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] level,
  output logic [NUM_BTNS-1:0] press_pulse,
  output logic [NUM_BTNS-1:0] release_pulse,
  output logic [NUM_BTNS-1:0] repeat_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Repeat counter sized for the longer of the two intervals; at least 1 bit.
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  localparam logic INVERT  = (ACTIVE_LOW != 0);
  localparam logic RPT_ON  = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } rpt_state_e;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    logic              sync1_q, sync2_q;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              repeat_q, repeat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    rpt_state_e        state_q, state_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        cnt_q     <= '0;
        rcnt_q    <= '0;
        state_q   <= RELEASED;
      end else begin
        sync1_q   <= btn_in[i] ^ INVERT;
        sync2_q   <= sync1_q;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
        cnt_q     <= cnt_d;
        rcnt_q    <= rcnt_d;
        state_q   <= state_d;
      end
    end

    // Debounce: any agreeing sample clears the count, so separate glitches never accumulate.
    always_comb begin
      level_d   = level_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d   = sync2_q;
        cnt_d     = '0;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Repeat FSM keys off the same-edge press/release decisions; release wins over a due repeat.
    always_comb begin
      state_d  = state_q;
      rcnt_d   = rcnt_q;
      repeat_d = 1'b0;
      case (state_q)
        RELEASED: begin
          rcnt_d = '0;
          if (RPT_ON && press_d) begin
            state_d = HELD_DELAY;
          end
        end
        HELD_DELAY: begin
          if (release_d) begin
            state_d = RELEASED;
            rcnt_d  = '0;
          end else if (rcnt_q == DELAY_LAST) begin
            repeat_d = 1'b1;
            state_d  = HELD_REPEAT;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        HELD_REPEAT: begin
          if (release_d) begin
            state_d = RELEASED;
            rcnt_d  = '0;
          end else if (rcnt_q == PERIOD_LAST) begin
            repeat_d = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RELEASED;
          rcnt_d  = '0;
        end
      endcase
    end

    assign level[i]         = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign repeat_pulse[i]  = repeat_q;
  end

endmodule
